axi_vfifo_raw_ctrl_mc: RTL and testbench

AXI_VFIFO_RAW_CTRL_MC -- requirements
Module: axi_vfifo_raw_ctrl_mc

---
 rtl/axi_vfifo_raw_ctrl_mc.sv | 155 +++++++++++++++
 tb/tb_axi_vfifo_raw_ctrl_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_vfifo_raw_ctrl_mc.sv
// ---------------------------------------------------------------------------
// axi_vfifo_raw_ctrl_mc
//
// Multi-channel control block for an AXI virtual FIFO. Each channel runs its
// own RESET/IDLE/ACTIVE/STOP state machine. It takes configuration from
// cfg_* inputs and hands a frozen, AXI-aligned copy of it to the FIFO
// engines while the channel is ACTIVE. A shared synchronizer turns the
// asynchronous rst_req_int into a clock-aligned release (sync_rst).
//
// Ports
//   clk, rst_req_int           clock; asynchronous active-high reset
//   cfg_reset[CH_CNT]          per-channel synchronous reset request
//   cfg_enable[CH_CNT]         per-channel enable level
//   cfg_fifo_base_addr         CH_CNT x AXI_ADDR_WIDTH, channel n in slice n
//   cfg_fifo_size_mask         CH_CNT x LEN_WIDTH, channel n in slice n
//   sts_write_active/read      per-channel engine busy flags
//   fifo_reset/fifo_enable     per-channel engine controls (registered)
//   fifo_base_addr/size_mask   latched, aligned configuration (registered)
//   sts_flush_timeout          sticky: flush wait gave up on busy engines
//   sts_state                  CH_CNT x 2, RESET=0 IDLE=1 ACTIVE=2 STOP=3
// ---------------------------------------------------------------------------
module axi_vfifo_raw_ctrl_mc #(
    parameter int CH_CNT         = 4,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_STRB_WIDTH = 8,
    parameter int LEN_WIDTH      = AXI_ADDR_WIDTH,
    parameter int SYNC_STAGES    = 3,
    parameter int FLUSH_TIMEOUT  = 1024
) (
    input  logic                             clk,
    input  logic                             rst_req_int,
    input  logic [CH_CNT-1:0]                cfg_reset,
    input  logic [CH_CNT-1:0]                cfg_enable,
    input  logic [CH_CNT*AXI_ADDR_WIDTH-1:0] cfg_fifo_base_addr,
    input  logic [CH_CNT*LEN_WIDTH-1:0]      cfg_fifo_size_mask,
    input  logic [CH_CNT-1:0]                sts_write_active,
    input  logic [CH_CNT-1:0]                sts_read_active,
    output logic [CH_CNT-1:0]                fifo_reset,
    output logic [CH_CNT-1:0]                fifo_enable,
    output logic [CH_CNT*AXI_ADDR_WIDTH-1:0] fifo_base_addr,
    output logic [CH_CNT*LEN_WIDTH-1:0]      fifo_size_mask,
    output logic [CH_CNT-1:0]                sts_flush_timeout,
    output logic [CH_CNT*2-1:0]              sts_state
);

    localparam int STRB_SHIFT = $clog2(AXI_STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {AXI_ADDR_WIDTH{1'b1}} << STRB_SHIFT;
    // Inverted at address width first, then zero-extended/truncated, so a
    // wider LEN_WIDTH never picks up spurious upper ones.
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LOW = ~ADDR_MASK;
    localparam logic [LEN_WIDTH-1:0] LEN_LOW_MASK = LEN_WIDTH'(ADDR_LOW);

    localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = (FLUSH_TIMEOUT > 0) ? TW'(FLUSH_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Reset-release synchronizer: set asynchronously, drained by zeros.
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_rst;

    always_ff @(posedge clk or posedge rst_req_int) begin
        if (rst_req_int)
            sync_chain <= '1;
        else
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b0};
    end

    assign sync_rst = sync_chain[SYNC_STAGES-1];

    for (genvar n = 0; n < CH_CNT; n++) begin : g_ch
        state_t                    state;
        logic                      rst_q;
        logic                      en_q;
        logic [AXI_ADDR_WIDTH-1:0] base_q;
        logic [LEN_WIDTH-1:0]      mask_q;
        logic                      to_q;
        logic [TW-1:0]             timer;
        logic                      busy;

        assign busy = sts_write_active[n] | sts_read_active[n];

        always_ff @(posedge clk or posedge rst_req_int) begin
            if (rst_req_int) begin
                state  <= ST_RESET;
                rst_q  <= 1'b1;
                en_q   <= 1'b0;
                base_q <= '0;
                mask_q <= '0;
                to_q   <= 1'b0;
                timer  <= '0;
            end else if (cfg_reset[n] || sync_rst) begin
                // Any explicit reset request re-arms the flush wait and
                // clears the sticky timeout flag.
                state <= ST_RESET;
                rst_q <= 1'b1;
                en_q  <= 1'b0;
                to_q  <= 1'b0;
                timer <= '0;
            end else begin
                case (state)
                    ST_RESET: begin
                        if (!busy) begin
                            state <= ST_IDLE;
                            rst_q <= 1'b0;
                        end else if (FLUSH_TIMEOUT != 0) begin
                            // Engines still busy: give up after FLUSH_TIMEOUT
                            // busy cycles and record it.
                            if (timer == TO_LAST) begin
                                state <= ST_IDLE;
                                rst_q <= 1'b0;
                                to_q  <= 1'b1;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                    ST_IDLE: begin
                        if (cfg_enable[n]) begin
                            state  <= ST_ACTIVE;
                            en_q   <= 1'b1;
                            base_q <= cfg_fifo_base_addr[n*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] & ADDR_MASK;
                            mask_q <= cfg_fifo_size_mask[n*LEN_WIDTH +: LEN_WIDTH] | LEN_LOW_MASK;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!cfg_enable[n]) begin
                            state <= ST_STOP;
                            en_q  <= 1'b0;
                        end
                    end
                    default: begin
                        // STOP: wait for the engines to drain; enable is
                        // ignored until IDLE is reached.
                        if (!busy)
                            state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign fifo_reset[n]                                        = rst_q;
        assign fifo_enable[n]                                       = en_q;
        assign fifo_base_addr[n*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]   = base_q;
        assign fifo_size_mask[n*LEN_WIDTH +: LEN_WIDTH]             = mask_q;
        assign sts_flush_timeout[n]                                 = to_q;
        assign sts_state[n*2 +: 2]                                  = state;
    end

endmodule

// File: tb/tb_axi_vfifo_raw_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_axi_vfifo_raw_ctrl_mc
//
// Scenario bench for axi_vfifo_raw_ctrl_mc with CH_CNT=4, 16-bit addresses,
// 8-byte strobes, SYNC_STAGES=3 and FLUSH_TIMEOUT=16. Each scenario task
// pushes the expected per-channel output snapshot to a queue after driving
// stimulus and pops/compares it once the DUT has clocked.
// ---------------------------------------------------------------------------
module tb_axi_vfifo_raw_ctrl_mc;

    localparam int CH = 4;
    localparam int AW = 16;
    localparam int LW = 16;

    logic            clk;
    logic            rst_req_int;
    logic [CH-1:0]   cfg_reset;
    logic [CH-1:0]   cfg_enable;
    logic [CH*AW-1:0] cfg_fifo_base_addr;
    logic [CH*LW-1:0] cfg_fifo_size_mask;
    logic [CH-1:0]   sts_write_active;
    logic [CH-1:0]   sts_read_active;
    logic [CH-1:0]   fifo_reset;
    logic [CH-1:0]   fifo_enable;
    logic [CH*AW-1:0] fifo_base_addr;
    logic [CH*LW-1:0] fifo_size_mask;
    logic [CH-1:0]   sts_flush_timeout;
    logic [CH*2-1:0] sts_state;

    axi_vfifo_raw_ctrl_mc #(
        .CH_CNT         (CH),
        .AXI_ADDR_WIDTH (AW),
        .AXI_STRB_WIDTH (8),
        .LEN_WIDTH      (LW),
        .SYNC_STAGES    (3),
        .FLUSH_TIMEOUT  (16)
    ) dut (
        .clk                (clk),
        .rst_req_int        (rst_req_int),
        .cfg_reset          (cfg_reset),
        .cfg_enable         (cfg_enable),
        .cfg_fifo_base_addr (cfg_fifo_base_addr),
        .cfg_fifo_size_mask (cfg_fifo_size_mask),
        .sts_write_active   (sts_write_active),
        .sts_read_active    (sts_read_active),
        .fifo_reset         (fifo_reset),
        .fifo_enable        (fifo_enable),
        .fifo_base_addr     (fifo_base_addr),
        .fifo_size_mask     (fifo_size_mask),
        .sts_flush_timeout  (sts_flush_timeout),
        .sts_state          (sts_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot layout: {state[1:0], fifo_reset, fifo_enable, base[15:0], mask[15:0], timeout}
    typedef struct {
        string       name;
        int          ch;
        logic [36:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [36:0] act;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  exp_st   [CH];
    logic [15:0] exp_base [CH];
    logic [15:0] exp_mask [CH];
    logic        exp_to   [CH];

    function automatic logic [36:0] ev(input int ch);
        return {exp_st[ch], exp_st[ch] == 2'd0, exp_st[ch] == 2'd2,
                exp_base[ch], exp_mask[ch], exp_to[ch]};
    endfunction

    function automatic logic [36:0] snap(input int ch);
        return {sts_state[ch*2 +: 2], fifo_reset[ch], fifo_enable[ch],
                fifo_base_addr[ch*AW +: AW], fifo_size_mask[ch*LW +: LW],
                sts_flush_timeout[ch]};
    endfunction

    task automatic push_all(input string name);
        for (int c = 0; c < CH; c++) sb.push_back('{name, c, ev(c)});
    endtask

    task automatic set_cfg(input int ch, input logic [15:0] base, input logic [15:0] mask);
        cfg_fifo_base_addr[ch*AW +: AW] = base;
        cfg_fifo_size_mask[ch*LW +: LW] = mask;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_exp();
        for (int c = 0; c < CH; c++) begin
            exp_st[c] = 2'd0; exp_base[c] = '0; exp_mask[c] = '0; exp_to[c] = 1'b0;
        end
    endtask

    task automatic test_reset();
        clear_exp();
        repeat (2) step();
        push_all("reset_hold");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
        rst_req_int = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            for (int c = 0; c < CH; c++) exp_st[c] = (i < 4) ? 2'd0 : 2'd1;
            push_all((i < 4) ? "sync_hold" : "release_idle");
            while (sb.size() > 0) begin
                e = sb.pop_front(); act = snap(e.ch); checks++;
                if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
            end
        end
    endtask

    task automatic test_enable_latch();
        set_cfg(1, 16'h1234, 16'h00FF);
        cfg_enable[1] = 1'b1;
        step();
        exp_st[1] = 2'd2; exp_base[1] = 16'h1230; exp_mask[1] = 16'h00FF;
        push_all("enable_latch");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
        set_cfg(1, 16'hFFFF, 16'h0000);
        repeat (2) step();
        push_all("active_frozen");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
    endtask

    task automatic test_stop_drain();
        set_cfg(0, 16'h0008, 16'h000F);
        cfg_enable[0] = 1'b1;
        step();
        exp_st[0] = 2'd2; exp_base[0] = 16'h0008; exp_mask[0] = 16'h000F;
        push_all("ch0_active");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
        cfg_enable[0]       = 1'b0;
        sts_write_active[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp_st[0] = (i <= 10) ? 2'd3 : 2'd1;
            push_all((i <= 10) ? "stop_wait" : "stop_to_idle");
            while (sb.size() > 0) begin
                e = sb.pop_front(); act = snap(e.ch); checks++;
                if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
            end
            // Enable pulse during STOP must be ignored.
            if (i == 4)  cfg_enable[0] = 1'b1;
            if (i == 7)  cfg_enable[0] = 1'b0;
            if (i == 10) sts_write_active[0] = 1'b0;
        end
    endtask

    task automatic test_flush_timeout();
        cfg_reset[2]       = 1'b1;
        sts_read_active[2] = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            step();
            if (i == 0) cfg_reset[2] = 1'b0;
            exp_st[2] = (i < 16) ? 2'd0 : 2'd1;
            exp_to[2] = (i == 16);
            push_all((i < 16) ? "flush_wait" : "flush_timeout");
            while (sb.size() > 0) begin
                e = sb.pop_front(); act = snap(e.ch); checks++;
                if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
            end
        end
        sts_read_active[2] = 1'b0;
        repeat (3) step();
        set_cfg(2, 16'h4444, 16'h0FF0);
        cfg_enable[2] = 1'b1;
        step();
        exp_st[2] = 2'd2; exp_base[2] = 16'h4440; exp_mask[2] = 16'h0FF7;
        push_all("timeout_sticky");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
        cfg_reset[2]  = 1'b1;
        cfg_enable[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            cfg_reset[2] = 1'b0;
            exp_st[2] = (i == 0) ? 2'd0 : 2'd1;
            exp_to[2] = 1'b0;
            push_all((i == 0) ? "reset_clears_to" : "reset_exit_idle");
            while (sb.size() > 0) begin
                e = sb.pop_front(); act = snap(e.ch); checks++;
                if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
            end
        end
    endtask

    task automatic test_reset_beats_enable();
        set_cfg(3, 16'hABCD, 16'h0F00);
        cfg_reset[3]  = 1'b1;
        cfg_enable[3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            cfg_reset[3]  = 1'b0;
            cfg_enable[3] = 1'b0;
            exp_st[3] = (i == 0) ? 2'd0 : 2'd1;
            push_all((i == 0) ? "reset_wins" : "no_latch_idle");
            while (sb.size() > 0) begin
                e = sb.pop_front(); act = snap(e.ch); checks++;
                if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
            end
        end
    endtask

    task automatic test_async_reset();
        set_cfg(0, 16'h2227, 16'h0100);
        set_cfg(1, 16'h8001, 16'h00F0);
        set_cfg(2, 16'h0010, 16'h0000);
        set_cfg(3, 16'hFFFF, 16'hF000);
        cfg_enable = 4'hF;
        step();
        exp_st[0] = 2'd2; exp_base[0] = 16'h2220; exp_mask[0] = 16'h0107;
        exp_st[2] = 2'd2; exp_base[2] = 16'h0010; exp_mask[2] = 16'h0007;
        exp_st[3] = 2'd2; exp_base[3] = 16'hFFF8; exp_mask[3] = 16'hF007;
        push_all("all_active");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
        // Assert between edges: outputs must clear without a clock.
        #2 rst_req_int = 1'b1;
        #1;
        clear_exp();
        push_all("async_clear");
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = snap(e.ch); checks++;
            if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
        end
        step();
        rst_req_int = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            for (int c = 0; c < CH; c++) exp_st[c] = (i < 4) ? 2'd0 : ((i == 4) ? 2'd1 : 2'd2);
            if (i == 5) begin
                exp_base[0] = 16'h2220; exp_mask[0] = 16'h0107;
                exp_base[1] = 16'h8000; exp_mask[1] = 16'h00F7;
                exp_base[2] = 16'h0010; exp_mask[2] = 16'h0007;
                exp_base[3] = 16'hFFF8; exp_mask[3] = 16'hF007;
            end
            push_all((i < 4) ? "rerelease_hold" : ((i == 4) ? "rerelease_idle" : "reenable"));
            while (sb.size() > 0) begin
                e = sb.pop_front(); act = snap(e.ch); checks++;
                if (act !== e.val) begin errors++; $display("FAIL %s ch%0d actual=%h required=%h", e.name, e.ch, act, e.val); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_req_int        = 1'b1;
        cfg_reset          = '0;
        cfg_enable         = '0;
        cfg_fifo_base_addr = '0;
        cfg_fifo_size_mask = '0;
        sts_write_active   = '0;
        sts_read_active    = '0;
        test_reset();
        test_enable_latch();
        test_stop_drain();
        test_flush_timeout();
        test_reset_beats_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
